// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: run-time configurable UART transmitter fed from an AXI-Stream
// byte/word input through a small FIFO.
//
// Frame: start(0), DATA_WIDTH data bits (LSB- or MSB-first), optional
// odd/even parity, one or two stop bits(1). Every bit lasts max(prescale,1)*8
// clocks. Configuration is sampled when a word is popped, so changes made
// mid-frame only apply to later frames. Frames run back-to-back while the
// FIFO holds data.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   s_axis_tdata    - word to send
//   s_axis_tvalid   - tdata valid
//   s_axis_tready   - FIFO not full (combinational from FIFO state only)
//   prescale        - bit period = max(prescale,1)*8 clocks
//   cfg_parity      - 00/11 none, 01 odd, 10 even
//   cfg_stop2       - 1 selects two stop bits
//   cfg_msb_first   - 1 sends d[W-1] first
//   txd             - serial line, idles high (registered)
//   busy            - FSM active or FIFO non-empty (registered)
//   tx_done         - pulse on last cycle of final stop bit (registered)
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [15:0]           prescale,
  input  logic [1:0]            cfg_parity,
  input  logic                  cfg_stop2,
  input  logic                  cfg_msb_first,
  output logic                  txd,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BIDX_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  // Reload value of the bit-period down-counter: max(p,1)*8 - 1.
  function automatic logic [18:0] bit_last(input logic [15:0] p);
    logic [18:0] pe;
    pe = (p == 16'd0) ? 19'd1 : {3'd0, p};
    return (pe << 3) - 19'd1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] bit_reverse(input logic [DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] r;
    for (int i = 0; i < DATA_WIDTH; i++) r[i] = w[DATA_WIDTH-1-i];
    return r;
  endfunction

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] head;

  assign s_axis_tready = (count_q != FULL_CNT);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign fifo_empty    = (count_q == '0);
  assign head          = fifo_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  state_t                state_q, state_d;
  logic [18:0]           cnt_q, cnt_d;
  logic [18:0]           per_q, per_d;
  logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic                  stop_idx_q, stop_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  par_bit_q, par_bit_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  load_word;
  logic                  txd_q, txd_d, busy_q, busy_d, tx_done_q, tx_done_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    per_d      = per_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    shreg_d    = shreg_q;
    load_word  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) load_word = 1'b1;
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d   = S_DATA;
          cnt_d     = per_q;
          bit_idx_d = '0;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = per_q;
          if (bit_idx_q == LAST_BIT) begin
            state_d    = par_en_q ? S_PARITY : S_STOP;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + BIDX_W'(1);
            shreg_d   = shreg_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d    = S_STOP;
          cnt_d      = per_q;
          stop_idx_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
            cnt_d      = per_q;
          end else if (!fifo_empty) begin
            load_word = 1'b1;
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 19'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pop and shadow the frame configuration. MSB-first words are reversed
    // here so the data state always shifts out bit 0; parity is unaffected.
    if (load_word) begin
      state_d   = S_START;
      cnt_d     = bit_last(prescale);
      per_d     = bit_last(prescale);
      shreg_d   = cfg_msb_first ? bit_reverse(head) : head;
      par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
      par_bit_d = (^head) ^ (cfg_parity == 2'b01);
      stop2_d   = cfg_stop2;
    end
  end

  assign pop = load_word;

  // Outputs are registered from the next-state view so they line up with
  // the state they describe.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_bit_d;
      default:  txd_d = 1'b1;
    endcase
    busy_d    = (state_d != S_IDLE) || (count_d != '0);
    tx_done_d = (state_d == S_STOP) && (cnt_d == '0) && (!stop2_d || stop_idx_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      per_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      per_q      <= per_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      tx_done_q  <= tx_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= s_axis_tdata;
    shreg_q   <= shreg_d;
    par_bit_q <= par_bit_d;
  end

  assign txd     = txd_q;
  assign busy    = busy_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Testbench for uart_tx_cfg: scoreboard of expected frames built from the
// frame rules, and a line monitor that decodes txd and compares.
module tb_uart_tx_cfg;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [DW-1:0] tdata;
  logic          tvalid, tready;
  logic [15:0]   prescale;
  logic [1:0]    cfg_parity;
  logic          cfg_stop2, cfg_msb_first;
  logic          txd, busy, tx_done;

  logic [4:0]    tdata5;
  logic          tvalid5, tready5, txd5, busy5, done5;
  logic [15:0]   prescale5 = '0;
  logic [1:0]    par5      = '0;
  logic          stop2_5   = 1'b0;
  logic          msb5      = 1'b0;

  uart_tx_cfg #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .prescale(prescale), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .cfg_msb_first(cfg_msb_first),
    .txd(txd), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_cfg #(.DATA_WIDTH(5), .FIFO_DEPTH(2)) u_dut5 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(tdata5), .s_axis_tvalid(tvalid5), .s_axis_tready(tready5),
    .prescale(prescale5), .cfg_parity(par5), .cfg_stop2(stop2_5),
    .cfg_msb_first(msb5),
    .txd(txd5), .busy(busy5), .tx_done(done5)
  );

  typedef struct {
    logic [31:0] bits;    // expected line level per bit slot, slot 0 = start
    int          nbits;
    int          bitlen;
    logic [15:0] cap;     // value an LSB-first mid-bit capture should return
    bit          b2b;     // must start with no idle cycle after previous frame
  } frame_t;

  frame_t sb_q[$];
  int     n_checks    = 0;
  int     n_fail      = 0;
  int     frames_done = 0;
  bit     mon_busy    = 1'b0;

  task automatic check(input bit ok, input string name, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frame from the line rules.
  function automatic frame_t make_exp(input logic [15:0] word, input int w,
                                      input logic [1:0] par, input logic stop2,
                                      input logic msb, input logic [15:0] presc,
                                      input bit b2b);
    frame_t f;
    int ones;
    int n;
    f.bits = '0;
    f.cap  = '0;
    ones   = 0;
    n      = 1;                        // slot 0 is the start bit (0)
    for (int i = 0; i < w; i++) begin
      int src;
      src       = msb ? (w - 1 - i) : i;
      f.bits[n] = word[src];
      f.cap[i]  = word[src];
      ones     += int'(word[i]);
      n++;
    end
    if (par == 2'b10) begin f.bits[n] = (ones % 2 == 1); n++; end
    else if (par == 2'b01) begin f.bits[n] = (ones % 2 == 0); n++; end
    f.bits[n] = 1'b1; n++;
    if (stop2) begin f.bits[n] = 1'b1; n++; end
    f.nbits  = n;
    f.bitlen = ((presc == 16'd0) ? 1 : int'(presc)) * 8;
    f.b2b    = b2b;
    return f;
  endfunction

  // Monitor: decode each frame on txd against the head of the scoreboard.
  initial begin : monitor
    frame_t      e;
    int          len, done_at, idle_cnt, b, g;
    logic [31:0] bad;
    logic [15:0] cap;
    bit          aborted;
    idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst || txd !== 1'b0) begin
        idle_cnt++;
        continue;
      end
      check(sb_q.size() != 0, "frame_expected", sb_q.size(), 1);
      if (sb_q.size() == 0) begin
        g = 0;
        while (txd === 1'b0 && g < 20000) begin @(negedge clk); g++; end
        idle_cnt = 0;
        continue;
      end
      e        = sb_q.pop_front();
      mon_busy = 1'b1;
      if (e.b2b) check(idle_cnt == 0, "b2b_gap", idle_cnt, 0);
      len     = e.nbits * e.bitlen;
      bad     = '0;
      cap     = '0;
      done_at = -1;
      aborted = 1'b0;
      for (int c = 0; c < len; c++) begin
        if (c > 0) @(negedge clk);
        if (rst) begin aborted = 1'b1; break; end
        b = c / e.bitlen;
        if (txd !== e.bits[b]) bad[b] = 1'b1;
        if (tx_done === 1'b1 && done_at < 0) done_at = c;
        if ((c % e.bitlen) == e.bitlen / 2 && b >= 1 && b <= DW) cap[b-1] = txd;
      end
      if (!aborted) begin
        for (int i = 0; i < e.nbits; i++)
          check(!bad[i], $sformatf("bit_slot%0d", i), bad[i], 0);
        check(done_at == len - 1, "tx_done_cycle", done_at, len - 1);
        check(cap == e.cap, "capture", cap, e.cap);
        frames_done++;
      end
      idle_cnt = 0;
      mon_busy = 1'b0;
    end
  end

  task automatic send_word(input logic [DW-1:0] w, input frame_t e);
    int guard;
    guard  = 0;
    tdata  = w;
    tvalid = 1'b1;
    while (!tready && guard < 5000) begin @(negedge clk); guard++; end
    if (!tready) begin
      check(1'b0, "send_timeout", guard, 5000);
      tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(e);
    @(negedge clk);
    tvalid = 1'b0;
  endtask

  task automatic send_cur(input logic [DW-1:0] w, input bit b2b);
    send_word(w, make_exp({8'd0, w}, DW, cfg_parity, cfg_stop2, cfg_msb_first, prescale, b2b));
  endtask

  task automatic wait_idle(input int maxc);
    int c;
    c = 0;
    while ((sb_q.size() != 0 || mon_busy || busy) && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (c >= maxc) check(1'b0, "idle_timeout", c, maxc);
    @(negedge clk);
  endtask

  logic [DW-1:0] burst_w [DEPTH+2];
  logic [DW-1:0] rw;
  frame_t        f5;
  logic [6:0]    s5;
  int            k, guard, busy_low, base, d5;
  bit            saw_full, tr;

  initial begin : stim
    rst           = 1'b1;
    tdata         = '0;
    tvalid        = 1'b0;
    prescale      = 16'd6;
    cfg_parity    = 2'b00;
    cfg_stop2     = 1'b0;
    cfg_msb_first = 1'b0;
    tdata5        = '0;
    tvalid5       = 1'b0;
    repeat (3) @(negedge clk);
    check(txd === 1'b1, "reset_txd", txd, 1);
    check(busy === 1'b0, "reset_busy", busy, 0);
    check(tx_done === 1'b0, "reset_tx_done", tx_done, 0);
    check(tready === 1'b1, "reset_tready", tready, 1);
    rst = 1'b0;
    @(negedge clk);

    // 8N1, BIT=48, LSB-first 0x2D
    send_cur(8'h2D, 1'b0);
    wait_idle(3000);
    // MSB-first 0x2D
    cfg_msb_first = 1'b1;
    send_cur(8'h2D, 1'b0);
    wait_idle(3000);
    cfg_msb_first = 1'b0;
    // 8E2 then 8O1
    cfg_parity = 2'b10; cfg_stop2 = 1'b1;
    send_cur(8'h2D, 1'b0);
    wait_idle(3000);
    cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    send_cur(8'h2D, 1'b0);
    wait_idle(3000);
    cfg_parity = 2'b00;

    // 5-bit build, prescale 0 (BIT=8), 0x15
    f5 = make_exp(16'h0015, 5, 2'b00, 1'b0, 1'b0, 16'd0, 1'b0);
    check(tready5 === 1'b1, "w5_tready", tready5, 1);
    tdata5 = 5'h15; tvalid5 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tvalid5 = 1'b0;
    guard = 0;
    while (txd5 !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    check(txd5 === 1'b0, "w5_start", txd5, 0);
    s5 = '0; d5 = -1;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      if ((c % 8) == 4 && c / 8 < 7) s5[c/8] = txd5;
      if (done5 === 1'b1 && d5 < 0) d5 = c;
    end
    for (int i = 0; i < 7; i++) check(s5[i] == f5.bits[i], $sformatf("w5_bit%0d", i), s5[i], f5.bits[i]);
    check(d5 == f5.nbits * f5.bitlen - 1, "w5_tx_done_cycle", d5, f5.nbits * f5.bitlen - 1);
    check(busy5 === 1'b0, "w5_busy_after", busy5, 0);

    // Burst of DEPTH+2 words, tvalid held high
    prescale = 16'd1;
    for (int i = 0; i < DEPTH + 2; i++) burst_w[i] = DW'($urandom);
    base = frames_done; k = 0; saw_full = 1'b0; guard = 0;
    while (k < DEPTH + 2 && guard < 3000) begin
      tdata = burst_w[k]; tvalid = 1'b1;
      tr = tready;
      if (!tr) saw_full = 1'b1;
      @(posedge clk);
      if (tr) begin
        sb_q.push_back(make_exp({8'd0, burst_w[k]}, DW, cfg_parity, cfg_stop2, cfg_msb_first, prescale, k > 0));
        k++;
      end
      @(negedge clk);
      guard++;
    end
    tvalid = 1'b0;
    check(k == DEPTH + 2, "burst_accepted", k, DEPTH + 2);
    check(saw_full, "burst_tready_drop", saw_full, 1);
    busy_low = 0; guard = 0;
    while (frames_done < base + DEPTH + 2 && guard < 5000) begin
      if (!busy) busy_low++;
      @(negedge clk);
      guard++;
    end
    check(guard < 5000, "burst_done_timeout", guard, 5000);
    check(busy_low == 0, "burst_busy_held", busy_low, 0);
    @(negedge clk);
    check(busy === 1'b0, "busy_after_burst", busy, 0);
    wait_idle(3000);

    // Randomised groups of back-to-back frames
    for (int g = 0; g < 6; g++) begin
      cfg_parity    = 2'($urandom);
      cfg_stop2     = 1'($urandom);
      cfg_msb_first = 1'($urandom);
      prescale      = 16'($urandom_range(0, 3));
      for (int j = 0; j < 3; j++) begin
        rw = DW'($urandom);
        send_cur(rw, j > 0);
      end
      wait_idle(6000);
    end

    // Config change mid-frame: only the queued frame sees it
    cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_msb_first = 1'b0; prescale = 16'd2;
    send_cur(8'h3C, 1'b0);
    send_word(8'hC5, make_exp(16'h00C5, DW, 2'b10, 1'b0, 1'b0, 16'd3, 1'b1));
    repeat (30) @(negedge clk);
    cfg_parity = 2'b10; prescale = 16'd3;
    wait_idle(3000);
    cfg_parity = 2'b00; prescale = 16'd2;

    // Reset mid-data: line goes high at once, queued word discarded
    send_cur(8'h00, 1'b0);
    send_cur(8'hFF, 1'b1);
    guard = 0;
    while (txd !== 1'b0 && guard < 20) begin @(negedge clk); guard++; end
    repeat (24) @(negedge clk);
    check(txd === 1'b0, "pre_reset_txd", txd, 0);
    #2;
    rst = 1'b1;
    #1;
    check(txd === 1'b1, "async_reset_txd", txd, 1);
    check(busy === 1'b0, "async_reset_busy", busy, 0);
    check(tready === 1'b1, "async_reset_tready", tready, 1);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check(txd === 1'b1 && busy === 1'b0, "post_reset_idle", {busy, txd}, 1);
    send_cur(8'hA5, 1'b0);
    wait_idle(3000);

    check(sb_q.size() == 0, "scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
